// File: rtl/decode_if.sv
// Operand/result bundle between fetch/execute and the decode/write-back stage.
// The master side supplies the instruction fields and results; the slave side returns operands.
interface decode_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] test;

  modport master (
    output icode, rA, rB, valE, valM,
    input  valA, valB, test
  );

  modport slave (
    input  icode, rA, rB, valE, valM,
    output valA, valB, test
  );
endinterface

// File: rtl/decode.sv
// Y86-64 decode/write-back stage: 15 x 64-bit register file with combinational
// operand reads and up to two writes (valE, valM) per rising clock edge.
module decode (
  input  logic     clk,
  input  logic     rst_n,
  decode_if.slave  bus
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam int         NREGS  = 15;

  logic [63:0] regs [NREGS];
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  icode_e      op;

  assign op = icode_e'(bus.icode);

  // Source/destination selection; R_NONE means "no read" (reads as 0) or "no write".
  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    dst_e = R_NONE;
    dst_m = R_NONE;
    unique case (op)
      I_RRMOVQ: begin
        src_a = bus.rA;
        dst_e = bus.rB;
      end
      I_IRMOVQ: dst_e = bus.rB;
      I_RMMOVQ: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      I_MRMOVQ: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      I_OPQ: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      I_CALL: begin
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_RET: begin
        src_a = R_RSP;
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_PUSHQ: begin
        src_a = bus.rA;
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_POPQ: begin
        src_a = R_RSP;
        src_b = R_RSP;
        dst_e = R_RSP;
        dst_m = bus.rA;
      end
      default: ;
    endcase
  end

  // Reads are straight from the array with no write bypass: a same-edge write
  // becomes visible only after the edge.
  assign bus.valA = (src_a == R_NONE) ? 64'd0 : regs[src_a];
  assign bus.valB = (src_b == R_NONE) ? 64'd0 : regs[src_b];
  assign bus.test = regs[0];

  // NOTE: the register file is flops, not an SRAM macro, so it can and must be
  // cleared by the asynchronous reset; sequential state uses non-blocking
  // assignment so every entry updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 64'd0;
      end
    end else begin
      // valM is checked first so that popq into %rsp leaves the popped value.
      for (int i = 0; i < NREGS; i++) begin
        if (dst_m == 4'(i)) begin
          regs[i] <= bus.valM;
        end else if (dst_e == 4'(i)) begin
          regs[i] <= bus.valE;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode/write-back stage: reset, each write-back path,
// popq priority, suppressed destinations and asynchronous mid-operation reset.
module tb_decode;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  decode_if bus ();

  decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ve, input logic [63:0] vm);
    bus.icode = ic;
    bus.rA    = ra;
    bus.rB    = rb;
    bus.valE  = ve;
    bus.valM  = vm;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(4'h6, 4'h3, 4'h5, 64'd77, 64'd88);
    #3;
    checks++;
    if (bus.valA !== 64'd0) begin failures++; $display("FAIL reset_valA got=%0d want=0", bus.valA); end
    checks++;
    if (bus.valB !== 64'd0) begin failures++; $display("FAIL reset_valB got=%0d want=0", bus.valB); end
    checks++;
    if (bus.test !== 64'd0) begin failures++; $display("FAIL reset_test got=%0d want=0", bus.test); end
    // Hold reset through an edge with a write pending, then release quietly.
    @(posedge clk); #1;
    checks++;
    if (bus.valB !== 64'd0) begin failures++; $display("FAIL reset_hold_write got=%0d want=0", bus.valB); end
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, 64'd0, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(4'h6, 4'h3, 4'h5, 64'd0, 64'd0);
    #1;
    checks++;
    if (bus.valA !== 64'd0 || bus.valB !== 64'd0 || bus.test !== 64'd0) begin
      failures++;
      $display("FAIL reset_release got=%0d/%0d/%0d want=0/0/0", bus.valA, bus.valB, bus.test);
    end
  endtask

  task automatic test_mrmovq;
    @(negedge clk);
    drive(4'h5, 4'h0, 4'h0, 64'd100, 64'd101);
    #1;
    checks++;
    if (bus.valA !== 64'd0 || bus.valB !== 64'd0) begin
      failures++; $display("FAIL mrmovq_pre got=%0d/%0d want=0/0", bus.valA, bus.valB);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.test !== 64'd101) begin failures++; $display("FAIL mrmovq_test got=%0d want=101", bus.test); end
    checks++;
    if (bus.valB !== 64'd101) begin failures++; $display("FAIL mrmovq_valB got=%0d want=101", bus.valB); end
  endtask

  task automatic test_call;
    @(negedge clk);
    drive(4'h8, 4'h1, 4'h0, 64'd100, 64'd0);
    #1;
    checks++;
    if (bus.valA !== 64'd0 || bus.valB !== 64'd0) begin
      failures++; $display("FAIL call_pre got=%0d/%0d want=0/0", bus.valA, bus.valB);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.valB !== 64'd100) begin failures++; $display("FAIL call_rsp got=%0d want=100", bus.valB); end
    checks++;
    if (bus.test !== 64'd101) begin failures++; $display("FAIL call_test got=%0d want=101", bus.test); end
  endtask

  task automatic test_opq;
    @(negedge clk);
    drive(4'h6, 4'h4, 4'h3, 64'd100, 64'd0);
    #1;
    checks++;
    if (bus.valA !== 64'd100 || bus.valB !== 64'd0) begin
      failures++; $display("FAIL opq_pre got=%0d/%0d want=100/0", bus.valA, bus.valB);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.valB !== 64'd100 || bus.valA !== 64'd100) begin
      failures++; $display("FAIL opq_post got=%0d/%0d want=100/100", bus.valA, bus.valB);
    end
  endtask

  task automatic test_popq_rsp;
    @(negedge clk);
    drive(4'hB, 4'h4, 4'hF, 64'd200, 64'd300);
    #1;
    checks++;
    if (bus.valA !== 64'd100 || bus.valB !== 64'd100) begin
      failures++; $display("FAIL popq_rsp_pre got=%0d/%0d want=100/100", bus.valA, bus.valB);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.valA !== 64'd300 || bus.valB !== 64'd300) begin
      failures++; $display("FAIL popq_rsp_post got=%0d/%0d want=300/300", bus.valA, bus.valB);
    end
  endtask

  task automatic test_popq_split;
    // popq %rdx: %rsp takes valE, %rdx takes valM.
    @(negedge clk);
    drive(4'hB, 4'h2, 4'hF, 64'd400, 64'd500);
    @(posedge clk); #1;
    checks++;
    if (bus.valB !== 64'd400) begin failures++; $display("FAIL popq_split_rsp got=%0d want=400", bus.valB); end
    @(negedge clk);
    drive(4'h2, 4'h2, 4'h5, 64'd777, 64'd0);
    #1;
    checks++;
    if (bus.valA !== 64'd500 || bus.valB !== 64'd0) begin
      failures++; $display("FAIL popq_split_rdx got=%0d/%0d want=500/0", bus.valA, bus.valB);
    end
  endtask

  task automatic test_rrmovq_rmmovq;
    // rrmovq from the previous task is still on the inputs: R[5] <= 777.
    @(posedge clk); #1;
    @(negedge clk);
    drive(4'h4, 4'h5, 4'h5, 64'd1, 64'd2);
    #1;
    checks++;
    if (bus.valA !== 64'd777 || bus.valB !== 64'd777) begin
      failures++; $display("FAIL rmmovq_read got=%0d/%0d want=777/777", bus.valA, bus.valB);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.valA !== 64'd777 || bus.test !== 64'd101) begin
      failures++; $display("FAIL rmmovq_nowrite got=%0d/%0d want=777/101", bus.valA, bus.test);
    end
  endtask

  task automatic test_halt_ret;
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, 64'd9, 64'd9);
    #1;
    checks++;
    if (bus.valA !== 64'd0 || bus.valB !== 64'd0) begin
      failures++; $display("FAIL halt_read got=%0d/%0d want=0/0", bus.valA, bus.valB);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.test !== 64'd101) begin failures++; $display("FAIL halt_nowrite got=%0d want=101", bus.test); end
    @(negedge clk);
    drive(4'h9, 4'h0, 4'h0, 64'd408, 64'd0);
    #1;
    checks++;
    if (bus.valA !== 64'd400 || bus.valB !== 64'd400) begin
      failures++; $display("FAIL ret_pre got=%0d/%0d want=400/400", bus.valA, bus.valB);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.valA !== 64'd408) begin failures++; $display("FAIL ret_post got=%0d want=408", bus.valA); end
  endtask

  task automatic test_no_dest;
    @(negedge clk);
    drive(4'h3, 4'h0, 4'hF, 64'd55, 64'd0);
    @(posedge clk); #1;
    checks++;
    if (bus.valB !== 64'd0) begin failures++; $display("FAIL nodest_valB got=%0d want=0", bus.valB); end
    checks++;
    if (bus.test !== 64'd101) begin failures++; $display("FAIL nodest_test got=%0d want=101", bus.test); end
    @(negedge clk);
    drive(4'h6, 4'h3, 4'h5, 64'd0, 64'd0);
    #1;
    checks++;
    if (bus.valA !== 64'd100 || bus.valB !== 64'd777) begin
      failures++; $display("FAIL nodest_others got=%0d/%0d want=100/777", bus.valA, bus.valB);
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    drive(4'h4, 4'h5, 4'h4, 64'd0, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.test !== 64'd0) begin failures++; $display("FAIL midrst_test got=%0d want=0", bus.test); end
    checks++;
    if (bus.valA !== 64'd0 || bus.valB !== 64'd0) begin
      failures++; $display("FAIL midrst_read got=%0d/%0d want=0/0", bus.valA, bus.valB);
    end
    // A write presented during reset must be discarded.
    drive(4'h3, 4'h0, 4'h0, 64'd99, 64'd0);
    @(posedge clk); #1;
    checks++;
    if (bus.test !== 64'd0) begin failures++; $display("FAIL midrst_blocked got=%0d want=0", bus.test); end
    @(negedge clk);
    drive(4'h4, 4'h5, 4'h3, 64'd0, 64'd0);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.valA !== 64'd0 || bus.valB !== 64'd0 || bus.test !== 64'd0) begin
      failures++; $display("FAIL midrst_after got=%0d/%0d/%0d want=0/0/0", bus.valA, bus.valB, bus.test);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 64'd0, 64'd0);
    test_reset();
    test_mrmovq();
    test_call();
    test_opq();
    test_popq_rsp();
    test_popq_split();
    test_rrmovq_rmmovq();
    test_halt_ret();
    test_no_dest();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Decode/write-back stage of the Y86-64 sequential processor, holding the 15-entry 64-bit program register file. It selects and reads the source operands valA/valB from icode, rA and rB, and commits valE/valM results to the register file on the rising clock edge. It sits between fetch (icode, rA, rB) and execute/memory (valE, valM), and exposes %rax on a debug port.

## Interface
- No parameters.
- clk  in  1  rising-edge clock; register-file writes occur on this edge.
- rst_n  in  1  asynchronous, active-low reset; clears the register file.
- icode  in  4  instruction code from fetch.
- rA  in  4  register specifier A; 0x0–0xE = %rax..%r14, 0xF = none.
- rB  in  4  register specifier B; same encoding as rA.
- valE  in  64  execute result to write back.
- valM  in  64  memory read result to write back.
- valA  out  64  operand A, combinational.
- valB  out  64  operand B, combinational.
- test  out  64  debug view: current contents of R[0] (%rax), combinational.

## Operation
- Register file: R[0..14], 64 bits each. %rsp is index 4. Index 0xF reads as 0, and writes to it are discarded.
- srcA / valA:
  - icode 2 (rrmovq), 4 (rmmovq), 6 (OPq), A (pushq): valA = R[rA].
  - icode 9 (ret), B (popq): valA = R[4].
  - All other icodes: valA = 0.
- srcB / valB:
  - icode 4, 5 (mrmovq), 6: valB = R[rB].
  - icode 8 (call), 9, A, B: valB = R[4].
  - All other icodes: valB = 0.
- Write-back on each rising clk edge while rst_n = 1:
  - icode 2, 3 (irmovq), 6: R[rB] <= valE. rrmovq/cmovXX writes unconditionally; there is no condition input.
  - icode 5: R[rA] <= valM.
  - icode 8, 9, A: R[4] <= valE.
  - icode B: R[4] <= valE and R[rA] <= valM. If rA = 4, the valM write wins, so R[4] = valM.
  - icode 0 (halt), 1 (nop), 7 (jXX), and C–F: no write, and valA = valB = 0.
- Each write destination is an ordinary register index. A destination of 0xF suppresses that write.
- All arithmetic is 64-bit pass-through. No computation occurs in this block.

## Timing
- Reset: asserting rst_n = 0 clears all R[i] to 0 immediately, regardless of clk.
  - While reset is held: test = 0, and valA/valB read 0 for every selection.
  - Writes are blocked while reset is held.
  - A reset asserted mid-operation discards any pending write.
- Reads are combinational with zero latency. valA, valB and test reflect the current register state and the current icode/rA/rB.
- Writes have one-edge latency. Values written at edge N are visible on valA/valB/test immediately after edge N.
- Same-cycle read and write of the same register:
  - Before the edge, outputs show the old value. There is no bypass.
  - After the edge, outputs show the new value.
- At most two writes occur per edge (popq only). Their priority is defined in Operation.

## Test plan
- Reset check: rst_n = 0 with any rA/rB and icode = 6. Required: valA = valB = test = 0. Release reset; values stay 0 until the first write.
- mrmovq: icode = 5, rA = 0, rB = 0, valE = 100, valM = 101.
  - Before the edge: valB = 0, valA = 0.
  - After the rising edge: R[0] = 101, test = 101, valB = 101.
- call: icode = 8, rA = 1, rB = 0, valE = 100.
  - Required: valA = 0 and valB = R[4] = 0.
  - After the edge: R[4] = 100, test unchanged at 101.
- OPq: icode = 6, rA = 4, rB = 3, valE = 100.
  - Required: valA = 100 and valB = R[3] = 0.
  - After the edge: R[3] = 100 and valB = 100.
- popq into %rsp: icode = B, rA = 4, valE = 200, valM = 300.
  - Before the edge: valA = valB = R[4].
  - After the edge: R[4] = 300.
- rB = 0xF with icode = 3, valE = 55: the edge writes nothing and valB stays 0.
- Mid-operation reset: pulse rst_n low between edges. Required: all registers, including R[0] (test), read 0 immediately.
